// File: rtl/multi_player_mover.sv
// N-player movement engine: per-player turn queue, sustained motion, timed speed boost,
// saturating y and optionally wrapping x, all advanced on a shared movement tick.
module multi_player_mover #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 10,
  parameter int STEP_DIV    = 500000,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int WRAP_X      = 1,
  parameter int POWER_TICKS = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [4*NUM_PLAYERS-1:0]       dir_req,
  input  logic [4*NUM_PLAYERS-1:0]       blocked,
  input  logic [NUM_PLAYERS-1:0]         powerup_hit,
  input  logic [COORD_W*NUM_PLAYERS-1:0] init_x,
  input  logic [COORD_W*NUM_PLAYERS-1:0] init_y,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_x,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_y,
  output logic [2*NUM_PLAYERS-1:0]       heading,
  output logic [NUM_PLAYERS-1:0]         moving,
  output logic [NUM_PLAYERS-1:0]         boosted,
  output logic                           tick
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int BT_W  = $clog2(POWER_TICKS + 1);
  localparam int EW    = COORD_W + 1;
  localparam logic [EW-1:0] X_LO = EW'(X_MIN);
  localparam logic [EW-1:0] X_HI = EW'(X_MAX);
  localparam logic [EW-1:0] Y_LO = EW'(Y_MIN);
  localparam logic [EW-1:0] Y_HI = EW'(Y_MAX);
  localparam logic WRAP_EN = (WRAP_X != 0);

  logic [CNT_W-1:0] count_reg;
  logic             tick_reg;
  logic             eval;

  // eval marks the divider-wrap cycle; every player FSM advances on that edge
  assign eval = enable && (count_reg == CNT_W'(STEP_DIV - 1));
  assign tick = tick_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= eval;
      if (enable) count_reg <= eval ? '0 : count_reg + CNT_W'(1);
    end
  end

  // One-axis move, done one bit wider so a step below zero cannot alias to a large value
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] cur,
    input logic               neg,
    input logic [1:0]         step,
    input logic [EW-1:0]      lo,
    input logic [EW-1:0]      hi,
    input logic               wrap
  );
    logic [EW-1:0] ext;
    logic [EW-1:0] stp;
    logic [EW-1:0] res;
    ext = {1'b0, cur};
    stp = EW'(step);
    if (neg) begin
      if (ext < lo + stp) res = wrap ? hi : lo;
      else                res = ext - stp;
    end else begin
      if (ext + stp > hi) res = wrap ? lo : hi;
      else                res = ext + stp;
    end
    return res[COORD_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [3:0]         req, blk;
      logic [1:0]         q_dir_reg, heading_reg, mv_dir, req_dir, step;
      logic               q_valid_reg, moving_reg, go_q, go_h;
      logic [COORD_W-1:0] x_reg, y_reg, x_next, y_next;
      logic [BT_W-1:0]    boost_reg;

      assign req = dir_req[4*gi +: 4];
      assign blk = blocked[4*gi +: 4];

      // A fresh unblocked request wins; otherwise keep coasting if the current heading is open
      assign go_q    = q_valid_reg && !blk[q_dir_reg];
      assign go_h    = moving_reg && !blk[heading_reg];
      assign mv_dir  = go_q ? q_dir_reg : heading_reg;
      assign step    = (boost_reg != '0) ? 2'd2 : 2'd1;
      assign req_dir = req[1] ? 2'd1 : req[2] ? 2'd2 : req[3] ? 2'd3 : 2'd0;

      always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        case (mv_dir)
          2'd0:    y_next = step_axis(y_reg, 1'b1, step, Y_LO, Y_HI, 1'b0);
          2'd1:    x_next = step_axis(x_reg, 1'b0, step, X_LO, X_HI, WRAP_EN);
          2'd2:    y_next = step_axis(y_reg, 1'b0, step, Y_LO, Y_HI, 1'b0);
          default: x_next = step_axis(x_reg, 1'b1, step, X_LO, X_HI, WRAP_EN);
        endcase
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          x_reg       <= init_x[COORD_W*gi +: COORD_W];
          y_reg       <= init_y[COORD_W*gi +: COORD_W];
          q_valid_reg <= 1'b0;
          q_dir_reg   <= 2'd0;
          heading_reg <= 2'd0;
          moving_reg  <= 1'b0;
          boost_reg   <= '0;
        end else begin
          if (enable && $onehot(req)) begin
            q_valid_reg <= 1'b1;
            q_dir_reg   <= req_dir;
          end
          if (eval) begin
            if (go_q || go_h) begin
              x_reg       <= x_next;
              y_reg       <= y_next;
              heading_reg <= mv_dir;
              moving_reg  <= 1'b1;
            end else begin
              moving_reg  <= 1'b0;
            end
          end
          if (powerup_hit[gi])             boost_reg <= BT_W'(POWER_TICKS);
          else if (eval && boost_reg != '0) boost_reg <= boost_reg - BT_W'(1);
        end
      end

      assign pos_x[COORD_W*gi +: COORD_W] = x_reg;
      assign pos_y[COORD_W*gi +: COORD_W] = y_reg;
      assign heading[2*gi +: 2]           = heading_reg;
      assign moving[gi]                   = moving_reg;
      assign boosted[gi]                  = (boost_reg != '0);
    end
  endgenerate

endmodule

// File: tb/tb_multi_player_mover.sv
// Checks two mover instances (x wrap on / off) against a cycle-level behavioural model
// using directed scenarios followed by randomized switches, collisions and powerups.
module tb_multi_player_mover;
  localparam int SD = 4;
  localparam int PT = 3;
  localparam int XMIN = 0, XMAX = 639, YMIN = 0, YMAX = 479;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  dir_req = '0;
  logic [7:0]  blocked = '0;
  logic [1:0]  powerup_hit = '0;
  logic [19:0] init_x = '0;
  logic [19:0] init_y = '0;

  logic [19:0] px[2], py[2];
  logic [3:0]  hd[2];
  logic [1:0]  mv[2], bs[2];
  logic        tk[2];

  int tests = 0;
  int fails = 0;

  // model state: positions per instance [w][p] (w=0 wraps, w=1 clamps), the rest per player
  int m_x[2][2], m_y[2][2];
  int m_hd[2], m_mv[2], m_qv[2], m_qd[2], m_bt[2];
  int m_cnt, m_tick;

  always #5 clock = ~clock;

  multi_player_mover #(.NUM_PLAYERS(2), .COORD_W(10), .STEP_DIV(SD), .X_MIN(XMIN), .X_MAX(XMAX),
    .Y_MIN(YMIN), .Y_MAX(YMAX), .WRAP_X(1), .POWER_TICKS(PT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dir_req(dir_req), .blocked(blocked),
    .powerup_hit(powerup_hit), .init_x(init_x), .init_y(init_y), .pos_x(px[0]), .pos_y(py[0]),
    .heading(hd[0]), .moving(mv[0]), .boosted(bs[0]), .tick(tk[0]));

  multi_player_mover #(.NUM_PLAYERS(2), .COORD_W(10), .STEP_DIV(SD), .X_MIN(XMIN), .X_MAX(XMAX),
    .Y_MIN(YMIN), .Y_MAX(YMAX), .WRAP_X(0), .POWER_TICKS(PT)) dut_clamp (
    .clock(clock), .reset(reset), .enable(enable), .dir_req(dir_req), .blocked(blocked),
    .powerup_hit(powerup_hit), .init_x(init_x), .init_y(init_y), .pos_x(px[1]), .pos_y(py[1]),
    .heading(hd[1]), .moving(mv[1]), .boosted(bs[1]), .tick(tk[1]));

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fx(input logic [19:0] v, input int p);
    return 32'(v[p*10 +: 10]);
  endfunction

  // Advance one player's position by s in direction d
  task automatic model_move(input int p, input int d, input int s);
    for (int w = 0; w < 2; w++) begin
      case (d)
        0: m_y[w][p] = (m_y[w][p] - s < YMIN) ? YMIN : m_y[w][p] - s;
        2: m_y[w][p] = (m_y[w][p] + s > YMAX) ? YMAX : m_y[w][p] + s;
        1: m_x[w][p] = (m_x[w][p] + s > XMAX) ? ((w == 0) ? XMIN : XMAX) : m_x[w][p] + s;
        default: m_x[w][p] = (m_x[w][p] - s < XMIN) ? ((w == 0) ? XMAX : XMIN) : m_x[w][p] - s;
      endcase
    end
  endtask

  // Model the effect of the coming clock edge from the inputs currently applied
  task automatic model_edge();
    bit wrap;
    int req, blk, s;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int w = 0; w < 2; w++) begin
          m_x[w][p] = fx(init_x, p);
          m_y[w][p] = fx(init_y, p);
        end
        m_hd[p] = 0; m_mv[p] = 0; m_qv[p] = 0; m_qd[p] = 0; m_bt[p] = 0;
      end
      m_cnt = 0; m_tick = 0;
      return;
    end
    if (!enable) begin
      m_tick = 0;
      for (int p = 0; p < 2; p++) if (powerup_hit[p]) m_bt[p] = PT;
      return;
    end
    wrap = (m_cnt == SD - 1);
    m_cnt = (m_cnt + 1) % SD;
    m_tick = int'(wrap);
    for (int p = 0; p < 2; p++) begin
      req = int'(dir_req[4*p +: 4]);
      blk = int'(blocked[4*p +: 4]);
      if (wrap) begin
        s = (m_bt[p] > 0) ? 2 : 1;
        if (m_qv[p] != 0 && blk[m_qd[p]] == 0) begin
          m_mv[p] = 1; m_hd[p] = m_qd[p]; model_move(p, m_qd[p], s);
        end else if (m_mv[p] != 0 && blk[m_hd[p]] == 0) begin
          model_move(p, m_hd[p], s);
        end else begin
          m_mv[p] = 0;
        end
      end
      if (powerup_hit[p]) m_bt[p] = PT;
      else if (wrap && m_bt[p] > 0) m_bt[p] = m_bt[p] - 1;
      if ($countones(req) == 1) begin
        m_qv[p] = 1;
        for (int d = 0; d < 4; d++) if (req[d]) m_qd[p] = d;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("pos_x w%0d p%0d", w, p), fx(px[w], p), m_x[w][p]);
        check($sformatf("pos_y w%0d p%0d", w, p), fx(py[w], p), m_y[w][p]);
        check($sformatf("heading w%0d p%0d", w, p), 32'(hd[w][2*p +: 2]), m_hd[p]);
        check($sformatf("moving w%0d p%0d", w, p), 32'(mv[w][p]), m_mv[p]);
        check($sformatf("boosted w%0d p%0d", w, p), 32'(bs[w][p]), int'(m_bt[p] > 0));
      end
      check($sformatf("tick w%0d", w), 32'(tk[w]), m_tick);
    end
    if (tk[0])
      $display("[TB] tick t=%0t p0=(%0d,%0d) p1=(%0d,%0d) p1clamp_x=%0d", $time,
               fx(px[0], 0), fx(py[0], 0), fx(px[0], 1), fx(py[0], 1), fx(px[1], 1));
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * SD && !seen; i++) begin
      step();
      seen = tk[0];
    end
    check("tick_timeout", int'(seen), 1);
  endtask

  task automatic do_reset(input int x0, input int x1, input int y0, input int y1);
    init_x = {10'(x1), 10'(x0)};
    init_y = {10'(y1), 10'(y0)};
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_dir(input logic [7:0] d);
    dir_req = d;
    step();
    dir_req = '0;
  endtask

  initial begin
    do_reset(10, 20, 30, 40);
    check("rst_px0", fx(px[0], 0), 10);
    check("rst_px1", fx(px[0], 1), 20);
    check("rst_moving", 32'(mv[0]), 0);

    // queue right, then keep coasting after the request is released
    wait_tick();
    pulse_dir(8'b0000_0010);
    wait_tick(); check("right_x11", fx(px[0], 0), 11); check("right_hd", 32'(hd[0][1:0]), 1);
    wait_tick(); check("coast_x12", fx(px[0], 0), 12);
    wait_tick(); check("coast_x13", fx(px[0], 0), 13);

    // up queued but blocked: continue right, then turn once the block clears
    blocked = 8'b0000_0001;
    pulse_dir(8'b0000_0001);
    wait_tick(); check("blk_up_x14", fx(px[0], 0), 14);
    blocked = '0;
    wait_tick(); check("turn_up_y29", fx(py[0], 0), 29);

    // heading right into a wall stops, release resumes
    pulse_dir(8'b0000_0010);
    wait_tick(); check("resume_x15", fx(px[0], 0), 15);
    blocked = 8'b0000_0010;
    wait_tick(); check("wall_stop", 32'(mv[0][0]), 0);
    wait_tick(); check("wall_hold_x", fx(px[0], 0), 15);
    blocked = '0;
    wait_tick(); check("wall_release_x16", fx(px[0], 0), 16);

    // tunnel wrap on x (clamp in the second instance)
    do_reset(10, 0, 30, 40);
    wait_tick();
    pulse_dir(8'b1000_0010);
    wait_tick();
    check("wrap_x639", fx(px[0], 1), 639);
    check("clamp_x0", fx(px[1], 1), 0);

    // boost: +2 for three ticks, multi-bit request ignored, enable=0 freezes everything
    powerup_hit = 2'b01; step(); powerup_hit = '0;
    wait_tick(); check("boost_x13", fx(px[0], 0), 13);
    dir_req = 8'b0000_0011; step(); step(); dir_req = '0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("freeze_x13", fx(px[0], 0), 13);
    enable = 1'b1;
    wait_tick(); check("boost_x15", fx(px[0], 0), 15);
    wait_tick(); check("boost_x17", fx(px[0], 0), 17); check("boost_off", 32'(bs[0][0]), 0);
    wait_tick(); check("normal_x18", fx(px[0], 0), 18);

    // randomized traffic
    do_reset(int'($urandom_range(0, 639)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), int'($urandom_range(476, 479)));
    for (int i = 0; i < 900; i++) begin
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 9))
          0, 1:    dir_req[4*p +: 4] = 4'(1 << $urandom_range(0, 3));
          2:       dir_req[4*p +: 4] = 4'($urandom_range(0, 15));
          default: dir_req[4*p +: 4] = '0;
        endcase
        for (int d = 0; d < 4; d++) blocked[4*p + d] = ($urandom_range(0, 5) == 0);
      end
      enable = ($urandom_range(0, 9) != 0);
      powerup_hit = enable ? 2'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0) : 2'b00;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
